raster_source: RTL and testbench
================================

Name: raster_source

Overview:
- Transmit end of the pixel-raster interface that the CNN feature extractor consumes: packed RGB pixel plus free-running vcnt/hcnt coordinates covering the full window, blanking included.
- Accepts pixels from an upstream producer through a valid/ready handshake and buffers them in a FIFO.
- Once primed, emits exactly one raster frame, or frames back-to-back, with no backpressure from the CNN side.

Parameters:
- HEIGHT, 4: active lines per frame.
- WIDTH, 4: active pixels per line.
- W_HEIGHT, 6: total lines per window incl. blanking; must be > HEIGHT.
- W_WIDTH, 6: total pixels per line incl. blanking; must be > WIDTH.
- UINT_BITW, 8: bits per colour channel.
- FIFO_DEPTH, 8: pixel FIFO entries; power of two, >= 2.
- PRIME_LEVEL, 4: FIFO occupancy required before the raster starts; 1..FIFO_DEPTH.

Ports:
- clock  in  1  single system clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-high (asserted when 1).
- start  in  1  one-cycle request to begin a frame.
- cont  in  1  sampled at frame end; 1 = run another frame immediately.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  FIFO can accept a pixel.
- in_rgb  in  UINT_BITW*3  pixel, {R,G,B}, R in MSBs.
- out_y  out  UINT_BITW*3  pixel to CNN, same packing.
- out_vcnt  out  log2(W_HEIGHT)  line coordinate.
- out_hcnt  out  log2(W_WIDTH)  pixel coordinate.
- busy  out  1  FSM not in IDLE.
- frame_done  out  1  one-cycle pulse on the last window position.
- underrun  out  1  sticky: an active position found the FIFO empty.

Behaviour:
- Reset values: out_y=0, out_vcnt=W_HEIGHT-1, out_hcnt=W_WIDTH-1, busy=0, frame_done=0, underrun=0, FIFO empty, FSM=IDLE.
- Reset is asynchronous: assertion mid-frame immediately returns everything to these values and discards FIFO contents.
- Handshake:
  - Push occurs when in_valid && in_ready.
  - in_ready = !full, combinational from FIFO count.
  - At full, in_ready is low; a pop in that cycle frees a slot for the next cycle only.
- FSM states:
  - IDLE: coordinates held at (W_HEIGHT-1, W_WIDTH-1), a blanking position; out_y=0. start -> PRIME; the same start clears underrun.
  - PRIME: waits until count >= PRIME_LEVEL -> RUN. start is ignored.
  - RUN: coordinates advance every cycle. start is ignored.
- Coordinate sequence:
  - The first RUN cycle registers (0,0); hcnt increments to W_WIDTH-1, then wraps to 0 and vcnt increments.
  - At (W_HEIGHT-1, W_WIDTH-1), frame_done pulses together with that registered position.
  - On the next edge: if cont=1, wrap to (0,0) and stay in RUN; else go to IDLE holding (W_HEIGHT-1, W_WIDTH-1).
- Pixel timing:
  - Position (v,h) is active iff v<HEIGHT && h<WIDTH.
  - Out_y and the coordinates are registered in the same edge, so the pixel is aligned with its coordinate, latency 0 relative to it.
  - The FIFO pop happens in the cycle whose next coordinate is active.
  - Blanking positions output out_y=0 and do not pop.
- Underrun: an active position with the FIFO empty outputs 0, sets underrun, and the raster does not stall.
- No fall-through: a push and a pop in the same cycle on an empty FIFO is an underrun; the pushed pixel remains for the next position.
- Arithmetic: counters unsigned, widths ceil(log2(W_*)); FIFO count width log2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: RASTER_SOURCE_TEST_PATTERN_EN.
- When defined:
  - Adds input pattern_sel.
  - When 1, active pixels are generated instead of popped: R=hcnt, G=vcnt, B=hcnt^vcnt, each zero-extended or truncated to UINT_BITW.
  - The FIFO is not popped and underrun is never set.
  - PRIME passes immediately when pattern_sel=1.
- When undefined: no port, no logic.

Decomposition:
- Package raster_pkg: FSM state encoding (IDLE=0, PRIME=1, RUN=2) and the ceil-log2 constant function.
- One sub-module, pixel_fifo: synchronous FIFO, registered data, full/empty/count outputs, asynchronous active-high reset.

Test Plan:
- Defaults; push 16 pixels 0x000001..0x000010, then start, cont=0:
  - out_y equals each pixel in order at (0,0)..(3,3).
  - Blanking positions output 0.
  - frame_done is high at (5,5), then FSM is IDLE and busy=0.
- Start with 3 pixels queued: stays in PRIME; a 4th push moves to RUN on the next edge and (0,0) appears one cycle later.
- Hold in_valid=1 with FIFO full: in_ready=0 and no push. One pop frees one slot, and in_ready=1 the following cycle.
- Supply only 10 pixels for the frame:
  - (2,2)..(3,3) output 0 and underrun goes high and stays high.
  - The next start in IDLE clears it.
- cont=1 over two frames:
  - (5,5) is followed directly by (0,0).
  - frame_done fires twice, 36 cycles apart.
- Assert n_rst mid-frame at (1,2): outputs go immediately to the reset values, FIFO count=0, underrun=0.

Source files
------------

// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
// Shared definitions for the raster source block:
//   - FSM state encoding (IDLE=0, PRIME=1, RUN=2), kept as plain logic
//     constants so older tools and netlists see a stable 2-bit encoding.
//   - clog2(): constant ceil-log2 used to size counters and ports.
// -----------------------------------------------------------------------------
package raster_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_PRIME = 2'd1;
   localparam state_t ST_RUN   = 2'd2;

   // Ceil-log2 with a floor of 1 so a width derived from it is never zero.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage : raster_pkg

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous FIFO holding packed RGB pixels between the upstream producer
// and the raster generator. Storage is a plain array; the head entry is read
// combinationally so the consumer can register it on the same edge it pops.
// There is no fall-through: a pixel pushed into an empty FIFO only becomes
// visible (empty=0) after the edge that stores it.
//
// Ports:
//   clock   in   rising-edge clock
//   n_rst   in   asynchronous reset, active high; empties the FIFO
//   push    in   write request (ignored while full)
//   pop     in   read request (ignored while empty)
//   wdata   in   DATA_W  pixel to store
//   rdata   out  DATA_W  pixel at the head of the FIFO
//   full    out  FIFO holds DEPTH entries
//   empty   out  FIFO holds no entries
//   count   out  clog2(DEPTH)+1 bits, current occupancy
// -----------------------------------------------------------------------------
module pixel_fifo
   import raster_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 24
) (
   input  logic                    clock,
   input  logic                    n_rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       wdata,
   output logic [DATA_W-1:0]       rdata,
   output logic                    full,
   output logic                    empty,
   output logic [clog2(DEPTH):0]   count
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_reg == FULL_COUNT);
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_reg];

   // Storage carries no reset; discarding contents is done by the pointers.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clock or posedge n_rst) begin
      if (n_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule : pixel_fifo

// File: rtl/raster_source.sv
// -----------------------------------------------------------------------------
// raster_source
// Transmit end of the pixel-raster interface feeding the CNN feature
// extractor. Pixels arrive over a valid/ready handshake into pixel_fifo.
// After a start request the block waits until PRIME_LEVEL pixels are queued,
// then sweeps the whole W_HEIGHT x W_WIDTH window (blanking included) one
// position per clock, never stalling. Active positions (v<HEIGHT, h<WIDTH)
// carry a popped pixel; blanking positions carry 0. An active position that
// finds the FIFO empty outputs 0 and sets the sticky underrun flag.
//
// Optional build macro RASTER_SOURCE_TEST_PATTERN_EN adds input pattern_sel:
// when 1, active pixels are synthesised as {hcnt, vcnt, hcnt^vcnt}, the FIFO
// is left untouched, underrun cannot set and PRIME is passed immediately.
//
// Ports:
//   clock        in   rising-edge clock
//   n_rst        in   asynchronous reset, active high
//   start        in   one-cycle frame request (acted on only in IDLE)
//   cont         in   sampled after the last window position; 1 = next frame
//   pattern_sel  in   (macro builds only) select generated test pattern
//   in_valid     in   upstream pixel valid
//   in_ready     out  FIFO not full
//   in_rgb       in   3*UINT_BITW packed {R,G,B}, R in MSBs
//   out_y        out  3*UINT_BITW pixel aligned with out_vcnt/out_hcnt
//   out_vcnt     out  line coordinate
//   out_hcnt     out  pixel coordinate
//   busy         out  FSM not in IDLE
//   frame_done   out  pulse with the last window position
//   underrun     out  sticky, cleared by the next accepted start
// -----------------------------------------------------------------------------
module raster_source
   import raster_pkg::*;
#(
   parameter int HEIGHT      = 4,
   parameter int WIDTH       = 4,
   parameter int W_HEIGHT    = 6,
   parameter int W_WIDTH     = 6,
   parameter int UINT_BITW   = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                          clock,
   input  logic                          n_rst,
   input  logic                          start,
   input  logic                          cont,
`ifdef RASTER_SOURCE_TEST_PATTERN_EN
   input  logic                          pattern_sel,
`endif
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [UINT_BITW*3-1:0]        in_rgb,
   output logic [UINT_BITW*3-1:0]        out_y,
   output logic [clog2(W_HEIGHT)-1:0]    out_vcnt,
   output logic [clog2(W_WIDTH)-1:0]     out_hcnt,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          underrun
);

   localparam int VW = clog2(W_HEIGHT);
   localparam int HW = clog2(W_WIDTH);
   localparam int PW = UINT_BITW * 3;
   localparam int CW = clog2(FIFO_DEPTH) + 1;

   localparam logic [VW-1:0] V_LAST    = VW'(W_HEIGHT - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(W_WIDTH - 1);
   localparam logic [VW-1:0] V_ACTIVE  = VW'(HEIGHT);
   localparam logic [HW-1:0] H_ACTIVE  = HW'(WIDTH);
   localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LEVEL);

   // ---------------------------------------------------------------- FIFO
   logic          fifo_push;
   logic          fifo_pop;
   logic [PW-1:0] fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   assign fifo_push = in_valid && in_ready;
   assign in_ready  = !fifo_full;

   pixel_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (PW)
   ) u_fifo (
      .clock (clock),
      .n_rst (n_rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (in_rgb),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ---------------------------------------------------------------- state
   state_t        state_reg,    state_next;
   logic [VW-1:0] vcnt_reg,     vcnt_next;
   logic [HW-1:0] hcnt_reg,     hcnt_next;
   logic [PW-1:0] y_reg,        y_next;
   logic          done_reg,     done_next;
   logic          underrun_reg, underrun_next;

   // Position the raster moves to if it advances this cycle. From the
   // parked (V_LAST, H_LAST) position this is (0,0), which is how the first
   // RUN cycle lands on the origin without a special case.
   logic          h_wrap;
   logic [VW-1:0] adv_v;
   logic [HW-1:0] adv_h;
   logic          adv_active;

   assign h_wrap     = (hcnt_reg == H_LAST);
   assign adv_h      = h_wrap ? '0 : hcnt_reg + 1'b1;
   assign adv_v      = !h_wrap ? vcnt_reg :
                       ((vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1);
   assign adv_active = (adv_v < V_ACTIVE) && (adv_h < H_ACTIVE);

`ifdef RASTER_SOURCE_TEST_PATTERN_EN
   logic [PW-1:0] pattern_pixel;

   assign pattern_pixel = {UINT_BITW'(adv_h),
                           UINT_BITW'(adv_v),
                           UINT_BITW'(adv_h) ^ UINT_BITW'(adv_v)};
`endif

   always_comb begin
      state_next    = state_reg;
      vcnt_next     = vcnt_reg;
      hcnt_next     = hcnt_reg;
      y_next        = y_reg;
      done_next     = 1'b0;
      underrun_next = underrun_reg;
      fifo_pop      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            vcnt_next = V_LAST;
            hcnt_next = H_LAST;
            y_next    = '0;
            if (start) begin
               state_next    = ST_PRIME;
               underrun_next = 1'b0;
            end
         end

         ST_PRIME: begin
`ifdef RASTER_SOURCE_TEST_PATTERN_EN
            if (pattern_sel || (fifo_count >= PRIME_CNT)) begin
`else
            if (fifo_count >= PRIME_CNT) begin
`endif
               state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            // done_reg marks that the registered position is the last of a
            // frame; that is the only place cont is looked at.
            if (done_reg && !cont) begin
               state_next = ST_IDLE;
               y_next     = '0;
            end else begin
               vcnt_next = adv_v;
               hcnt_next = adv_h;
               done_next = (adv_v == V_LAST) && (adv_h == H_LAST);
               y_next    = '0;
               if (adv_active) begin
`ifdef RASTER_SOURCE_TEST_PATTERN_EN
                  if (pattern_sel) begin
                     y_next = pattern_pixel;
                  end else
`endif
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     y_next   = fifo_rdata;
                  end else begin
                     underrun_next = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge n_rst) begin
      if (n_rst) begin
         state_reg    <= ST_IDLE;
         vcnt_reg     <= V_LAST;
         hcnt_reg     <= H_LAST;
         y_reg        <= '0;
         done_reg     <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         vcnt_reg     <= vcnt_next;
         hcnt_reg     <= hcnt_next;
         y_reg        <= y_next;
         done_reg     <= done_next;
         underrun_reg <= underrun_next;
      end
   end

   assign out_y      = y_reg;
   assign out_vcnt   = vcnt_reg;
   assign out_hcnt   = hcnt_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign frame_done = done_reg;
   assign underrun   = underrun_reg;

endmodule : raster_source

// File: tb/tb_raster_source.sv
// -----------------------------------------------------------------------------
// tb_raster_source
// Self-checking bench for raster_source with default parameters (4x4 active,
// 6x6 window, 8-entry FIFO, prime level 4). A background feeder drives the
// upstream handshake on the falling edge from a stimulus queue and records
// every accepted pixel in the expected-pixel queue; the main thread walks a
// table of window positions and pops an expected pixel for each active one.
// -----------------------------------------------------------------------------
module tb_raster_source;

   localparam int NPOS = 36;

   logic        clock = 1'b0;
   logic        n_rst = 1'b0;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic        in_valid = 1'b0;
   logic [23:0] in_rgb = '0;
   logic        in_ready;
   logic [23:0] out_y;
   logic [2:0]  out_vcnt;
   logic [2:0]  out_hcnt;
   logic        busy;
   logic        frame_done;
   logic        underrun;

   raster_source dut (
      .clock      (clock),
      .n_rst      (n_rst),
      .start      (start),
      .cont       (cont),
`ifdef RASTER_SOURCE_TEST_PATTERN_EN
      .pattern_sel(1'b0),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rgb     (in_rgb),
      .out_y      (out_y),
      .out_vcnt   (out_vcnt),
      .out_hcnt   (out_hcnt),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   always #5 clock = ~clock;

   typedef struct {
      int v;
      int h;
      bit active;
      bit done;
   } pos_t;

   pos_t        pos_tab [NPOS];
   logic [23:0] feed_q [$];
   logic [23:0] model_q [$];
   bit          model_ur = 1'b0;
   int          checks = 0;
   int          errors = 0;

   // Feeder: presents the head of feed_q; a pixel counts as accepted when
   // in_ready is high while it is presented, i.e. it is stored on the next
   // rising edge.
   initial begin
      forever begin
         @(negedge clock);
         if (feed_q.size() > 0) begin
            in_valid = 1'b1;
            in_rgb   = feed_q[0];
            if (in_ready && !n_rst) begin
               model_q.push_back(feed_q.pop_front());
            end
         end else begin
            in_valid = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // One window position: expected pixel comes from the scoreboard queue.
   task automatic check_pos(input int kk);
      int          k;
      logic [23:0] ey;
      logic [31:0] exp_w;
      logic [31:0] act_w;
      k  = kk % NPOS;
      ey = '0;
      if (pos_tab[k].active) begin
         if (model_q.size() > 0) ey = model_q.pop_front();
         else model_ur = 1'b1;
      end
      exp_w = {3'(pos_tab[k].v), 3'(pos_tab[k].h), ey, pos_tab[k].done, model_ur};
      act_w = {out_vcnt, out_hcnt, out_y, frame_done, underrun};
      checks++;
      if (act_w !== exp_w) begin
         errors++;
         $display("FAIL pos%0d: got v=%0d h=%0d y=%06h done=%0b ur=%0b expected v=%0d h=%0d y=%06h done=%0b ur=%0b",
                  kk, out_vcnt, out_hcnt, out_y, frame_done, underrun,
                  pos_tab[k].v, pos_tab[k].h, ey, pos_tab[k].done, model_ur);
      end else begin
         $display("pos%0d v=%0d h=%0d y=%06h done=%0b ur=%0b",
                  kk, out_vcnt, out_hcnt, out_y, frame_done, underrun);
      end
   endtask

   task automatic start_frame();
      start    = 1'b1;
      model_ur = 1'b0;
      step();
      start    = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_vcnt"}, 32'(out_vcnt), 5);
      chk({tag, "_hcnt"}, 32'(out_hcnt), 5);
      chk({tag, "_done"}, 32'(frame_done), 0);
      chk({tag, "_y"},    32'(out_y), 0);
   endtask

   initial begin
      for (int k = 0; k < NPOS; k++) begin
         pos_tab[k] = '{v: k / 6, h: k % 6,
                        active: ((k / 6) < 4) && ((k % 6) < 4),
                        done: (k == NPOS - 1)};
      end

      // ---- reset state
      #1 n_rst = 1'b1;
      step();
      check_idle("reset");
      chk("reset_underrun", 32'(underrun), 0);
      chk("reset_in_ready", 32'(in_ready), 1);
      n_rst = 1'b0;
      step();

      // ---- single frame, 16 pixels, cont=0
      for (int i = 1; i <= 16; i++) feed_q.push_back(24'(i));
      repeat (12) step();
      start_frame();
      chk("t1_busy_prime", 32'(busy), 1);
      step();
      step();
      for (int k = 0; k < NPOS; k++) begin
         check_pos(k);
         if (k < NPOS - 1) step();
      end
      step();
      check_idle("t1_end");

      // ---- stuck in PRIME with 3 pixels, 4th releases it
      for (int i = 0; i < 3; i++) feed_q.push_back(24'h200 + 24'(i));
      repeat (6) step();
      start_frame();
      repeat (4) step();
      chk("t2_prime_busy", 32'(busy), 1);
      chk("t2_prime_hcnt", 32'(out_hcnt), 5);
      feed_q.push_back(24'h203);
      step();
      chk("t2_push_vcnt", 32'(out_vcnt), 5);
      chk("t2_push_hcnt", 32'(out_hcnt), 5);
      step();
      chk("t2_run_vcnt", 32'(out_vcnt), 5);
      chk("t2_run_hcnt", 32'(out_hcnt), 5);
      step();
      for (int k = 0; k < NPOS; k++) begin
         check_pos(k);
         if (k < NPOS - 1) step();
      end
      step();
      chk("t2_underrun_sticky", 32'(underrun), 1);

      // ---- full FIFO, then a 10-pixel frame that underruns
      for (int i = 0; i < 10; i++) feed_q.push_back(24'h400 + 24'(i));
      repeat (12) step();
      chk("t3_full_ready", 32'(in_ready), 0);
      start_frame();
      chk("t3_start_clears_ur", 32'(underrun), 0);
      chk("t3_ready_prime", 32'(in_ready), 0);
      step();
      chk("t3_ready_run", 32'(in_ready), 0);
      step();
      chk("t3_ready_after_pop", 32'(in_ready), 1);
      for (int k = 0; k < NPOS; k++) begin
         check_pos(k);
         if (k < NPOS - 1) step();
      end
      step();
      chk("t3_underrun_sticky", 32'(underrun), 1);
      chk("t3_idle_busy", 32'(busy), 0);

      // ---- two back-to-back frames with cont=1
      for (int i = 0; i < 32; i++) feed_q.push_back(24'h800 + 24'(i));
      repeat (12) step();
      cont = 1'b1;
      start_frame();
      chk("t4_start_clears_ur", 32'(underrun), 0);
      step();
      step();
      for (int k = 0; k < 2 * NPOS; k++) begin
         check_pos(k);
         if (k == 40) cont = 1'b0;
         if (k < 2 * NPOS - 1) step();
      end
      step();
      check_idle("t4_end");

      // ---- asynchronous reset mid-frame at (1,2)
      for (int i = 0; i < 16; i++) feed_q.push_back(24'hA00 + 24'(i));
      repeat (12) step();
      start_frame();
      step();
      step();
      for (int k = 0; k <= 8; k++) begin
         check_pos(k);
         if (k < 8) step();
      end
      feed_q.delete();
      n_rst = 1'b1;
      #1;
      check_idle("t5_async");
      chk("t5_underrun", 32'(underrun), 0);
      chk("t5_fifo_count", 32'(dut.fifo_count), 0);
      model_q.delete();
      step();
      n_rst = 1'b0;
      step();
      chk("t5_after_busy", 32'(busy), 0);
      chk("t5_after_ready", 32'(in_ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_raster_source
